// File: rtl/data_bus_bridge.sv
// Bridges the memory stage's single-cycle SRAM port onto the SoC SRAM-like data bus,
// stalling the pipeline until the transaction completes or a timeout aborts it.
module data_bus_bridge #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic [3:0]  mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        stall,
    output logic        bus_error,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t        state;
    logic [CW-1:0] timeout_cnt;

    logic          hold_wr;
    logic [1:0]    hold_size;
    logic [31:0]   hold_addr;
    logic [3:0]    hold_wstrb;
    logic [31:0]   hold_wdata;

    logic          req_wr;
    logic [1:0]    req_size;
    logic [1:0]    req_off;
    logic [31:0]   req_addr;
    logic          addr_lsb_unused;

    // The bus address offset comes from the strobe pattern, not from the stage's low address bits.
    assign addr_lsb_unused = ^mem_addr[1:0];

    always_comb begin
        req_wr   = (mem_wen != 4'b0000);
        req_size = 2'd2;
        req_off  = 2'b00;
        case (mem_wen)
            4'b0001: begin req_size = 2'd0; req_off = 2'b00; end
            4'b0010: begin req_size = 2'd0; req_off = 2'b01; end
            4'b0100: begin req_size = 2'd0; req_off = 2'b10; end
            4'b1000: begin req_size = 2'd0; req_off = 2'b11; end
            4'b0011: begin req_size = 2'd1; req_off = 2'b00; end
            4'b1100: begin req_size = 2'd1; req_off = 2'b10; end
            default: ;
        endcase
        req_addr = {mem_addr[31:2], req_off};
    end

    // In IDLE the request goes out straight from the stage; afterwards it replays from the hold registers.
    always_comb begin
        bus_req   = rst & (((state == IDLE) & mem_en) | (state == ADDR));
        stall     = rst & mem_en & (state != DONE);
        bus_wr    = hold_wr;
        bus_size  = hold_size;
        bus_addr  = hold_addr;
        bus_wstrb = hold_wstrb;
        bus_wdata = hold_wdata;
        if (state == IDLE) begin
            bus_wr    = req_wr;
            bus_size  = req_size;
            bus_addr  = req_addr;
            bus_wstrb = mem_wen;
            bus_wdata = mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            timeout_cnt <= '0;
            hold_wr     <= 1'b0;
            hold_size   <= 2'd0;
            hold_addr   <= 32'h0;
            hold_wstrb  <= 4'h0;
            hold_wdata  <= 32'h0;
            mem_rdata   <= 32'h0;
            bus_error   <= 1'b0;
        end else begin
            bus_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_en) begin
                        hold_wr     <= req_wr;
                        hold_size   <= req_size;
                        hold_addr   <= req_addr;
                        hold_wstrb  <= mem_wen;
                        hold_wdata  <= mem_wdata;
                        timeout_cnt <= '0;
                        state       <= bus_addr_ok ? DATA : ADDR;
                    end
                end
                ADDR: begin
                    if (bus_addr_ok) begin
                        timeout_cnt <= '0;
                        state       <= DATA;
                    end
                end
                DATA: begin
                    // A response in the final allowed cycle beats the abort.
                    if (bus_data_ok) begin
                        if (!hold_wr)
                            mem_rdata <= bus_rdata;
                        state <= DONE;
                    end else if ((TIMEOUT != 0) && (timeout_cnt == LAST_CNT)) begin
                        mem_rdata <= 32'h0;
                        bus_error <= 1'b1;
                        state     <= DONE;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
